// File: rtl/note_result_scheduler.sv
// Debounces recognizer note indices into a committed note with octave/semitone,
// records committed notes in a history ring and streams it newest-first once per frame.
module note_result_scheduler #(
  parameter int NOTE_W     = 6,
  parameter int STABLE_CNT = 3,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NOTE_W-1:0]        d2_recognize_result,
  input  logic                     d2_recognize_result_step,
  input  logic                     frame_start,
  output logic [NOTE_W-1:0]        cur_note,
  output logic [1:0]               cur_octave,
  output logic [3:0]               cur_semitone,
  output logic                     new_note,
  output logic                     drop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NOTE_W-1:0]        out_note,
  output logic [$clog2(DEPTH)-1:0] out_index,
  output logic                     out_last
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SNAP, S_SEND, S_FLUSH} state_t;

  state_t            r_state;
  logic [NOTE_W-1:0] r_cand;
  logic [3:0]        r_run;
  logic [NOTE_W-1:0] r_ring [DEPTH];
  logic [IDX_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_pend_v;
  logic [NOTE_W-1:0] r_pend_note;
  logic [IDX_W-1:0]  r_newest;
  logic [IDX_W-1:0]  r_k;
  logic [CNT_W-1:0]  r_n;

  logic [NOTE_W-1:0] w_step_note;
  logic [3:0]        w_run_next;
  logic              w_commit;
  logic              w_push_req;
  logic [1:0]        w_octave;
  logic [NOTE_W-1:0] w_oct_base;
  logic [3:0]        w_semitone;
  logic              w_ring_phase;
  logic              w_wr_en;
  logic [NOTE_W-1:0] w_wr_data;
  logic [IDX_W-1:0]  w_newest_now;
  logic [IDX_W-1:0]  w_next_rd;
  logic              w_beat_done;

  // Invalid indices collapse to silence before they reach the run filter.
  always_comb begin
    w_step_note = '0;
    if ((d2_recognize_result != '0) && (d2_recognize_result <= NOTE_W'(36)))
      w_step_note = d2_recognize_result;

    w_run_next = 4'd1;
    if (w_step_note == r_cand)
      w_run_next = (r_run == 4'd15) ? 4'd15 : r_run + 4'd1;

    w_commit   = d2_recognize_result_step && (w_run_next == 4'(STABLE_CNT)) &&
                 (w_step_note != cur_note);
    w_push_req = w_commit && (w_step_note != '0);

    w_octave   = 2'd0;
    w_oct_base = '0;
    if (w_step_note >= NOTE_W'(25)) begin
      w_octave   = 2'd2;
      w_oct_base = NOTE_W'(24);
    end else if (w_step_note >= NOTE_W'(13)) begin
      w_octave   = 2'd1;
      w_oct_base = NOTE_W'(12);
    end
    w_semitone = (w_step_note == '0) ? 4'd0 : 4'(w_step_note - NOTE_W'(1) - w_oct_base);
  end

  assign w_ring_phase = (r_state == S_IDLE) || (r_state == S_FLUSH);
  assign w_wr_en      = w_ring_phase && (r_pend_v || w_push_req);
  assign w_wr_data    = r_pend_v ? r_pend_note : w_step_note;
  assign w_newest_now = r_wr_ptr - IDX_W'(1);
  assign w_next_rd    = r_newest - r_k - IDX_W'(1);
  assign w_beat_done  = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cand       <= '0;
      r_run        <= '0;
      cur_note     <= '0;
      cur_octave   <= '0;
      cur_semitone <= '0;
      new_note     <= 1'b0;
    end else begin
      new_note <= 1'b0;
      if (d2_recognize_result_step) begin
        r_cand <= w_step_note;
        r_run  <= w_run_next;
      end
      if (w_commit) begin
        cur_note     <= w_step_note;
        cur_octave   <= w_octave;
        cur_semitone <= w_semitone;
        new_note     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_ring[r_wr_ptr] <= w_wr_data;
  end

  // The ring only changes outside a burst; an older pending entry always lands first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_pend_v    <= 1'b0;
      r_pend_note <= '0;
      drop        <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + IDX_W'(1);
        if (r_count != CNT_W'(DEPTH))
          r_count <= r_count + CNT_W'(1);
      end
      if (w_ring_phase) begin
        if (r_pend_v) begin
          r_pend_v <= w_push_req;
          if (w_push_req)
            r_pend_note <= w_step_note;
        end
      end else if (w_push_req) begin
        r_pend_v    <= 1'b1;
        r_pend_note <= w_step_note;
        drop        <= r_pend_v;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_newest  <= '0;
      r_k       <= '0;
      r_n       <= '0;
      out_valid <= 1'b0;
      out_note  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_start)
            r_state <= S_SNAP;
        end
        S_SNAP: begin
          r_n       <= r_count;
          r_newest  <= w_newest_now;
          r_k       <= '0;
          out_valid <= 1'b1;
          out_index <= '0;
          out_note  <= (r_count == '0) ? '0 : r_ring[w_newest_now];
          out_last  <= (r_count <= CNT_W'(1));
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (w_beat_done) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_note  <= '0;
              out_index <= '0;
              out_last  <= 1'b0;
              r_state   <= S_FLUSH;
            end else begin
              r_k       <= r_k + IDX_W'(1);
              out_index <= r_k + IDX_W'(1);
              out_note  <= r_ring[w_next_rd];
              out_last  <= ((CNT_W'(r_k) + CNT_W'(2)) == r_n);
            end
          end
        end
        S_FLUSH: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/note_result_scheduler.md
# note_result_scheduler

Sits between the note recognizer and the SVGA renderer. Debounces the recognizer's per-step note index into a stable current note and splits it into octave/semitone. Keeps a history ring of committed notes. Once per video frame, streams that history newest-first to the renderer over a valid/ready handshake.

## Interface
- NOTE_W, 6: width of the note index. 0 = no note; 1..36 = three octaves × 12 semitones; 37..63 = invalid, treated as 0.
- STABLE_CNT, 3: number of consecutive identical steps needed to commit a note (range 1..15).
- DEPTH, 8: history ring entries (power of two, 2..16).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- d2_recognize_result  in  NOTE_W  recognizer note index, sampled only when the step strobe is high.
- d2_recognize_result_step  in  1  one-cycle strobe marking a new recognizer result.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- cur_note  out  NOTE_W  committed note (0 = silence).
- cur_octave  out  2  equal to (cur_note-1)/12; 0 when cur_note = 0.
- cur_semitone  out  4  equal to (cur_note-1)%12; 0 when cur_note = 0.
- new_note  out  1  one-cycle pulse when cur_note changes.
- drop  out  1  one-cycle pulse when a deferred history write is lost.
- out_valid  out  1  readout beat valid.
- out_ready  in  1  renderer accepts the beat.
- out_note  out  NOTE_W  history entry being sent.
- out_index  out  $clog2(DEPTH)  age of the entry: 0 = newest.
- out_last  out  1  marks the final beat of the frame's burst.

## Operation
- Reset: every output is 0, including cur_note, new_note, drop, out_*, ring count and pointers, candidate and run counter. The FSM enters IDLE.
- Filter, on each step strobe (invalid indices are first mapped to 0):
  - If the result equals the candidate, run = min(run+1, 15).
  - Otherwise, candidate = result and run = 1.
  - Commit when the updated run equals STABLE_CNT and the candidate differs from cur_note. A commit sets cur_note = candidate, pulses new_note, and, if the candidate is nonzero, requests a history push.
  - A run past STABLE_CNT does not commit again.
  - Silence (0) is committed to cur_note but is never pushed to history.
- Octave and semitone are registered; they update in the same cycle as cur_note.
- History ring:
  - A push writes at wr_ptr, then wr_ptr wraps modulo DEPTH.
  - count saturates at DEPTH; when full, the oldest entry is overwritten.
- Readout FSM:
  - IDLE: on frame_start, go to SNAP.
  - SNAP (1 cycle): latch n = count and the newest-entry pointer, then go to SEND.
  - SEND: present beats for k = 0..n-1, where out_note = ring[newest-k mod DEPTH], out_index = k, and out_last = (k == n-1). If n = 0, send one beat with out_note = 0, out_index = 0, out_last = 1. Leave SEND after the handshake on the last beat, then go to FLUSH.
  - FLUSH (1 cycle): perform any pending push, then return to IDLE.
- Pushes requested in SNAP or SEND are held in a single pending register; they never modify the ring mid-burst.
  - A second push while pending is full overwrites the pending register (latest wins) and pulses drop.
- frame_start in any state other than IDLE is ignored. Step strobes and commits continue in every FSM state.

## Timing
- Commit latency: step strobe at cycle T → cur_note, octave, semitone and new_note take effect at T+1.
- A push requested in IDLE is written at T+1. A frame_start at cycle ≥ T+1 includes that entry.
- frame_start at cycle F: SNAP at F+1, first out_valid at F+2.
- Handshake rules:
  - out_valid and the payload stay stable until out_ready is high.
  - After a transfer, the next beat is valid in the following cycle, giving 1 beat/cycle throughput with out_ready tied high.
  - out_valid drops the cycle after the last transfer.
- Burst length is n beats (minimum 1). With out_ready held high, the FSM is back in IDLE at F+2+n+1.
- Reset asserted mid-burst: the burst aborts and all state clears immediately (asynchronous). No beat is emitted after reset release until the next frame_start.
- A step strobe and frame_start in the same IDLE cycle: the push lands at T+1, before SNAP latches, so the burst includes it.

## Test plan
- Steps 5,5,5 → cur_note = 5 and new_note pulse one cycle after the third strobe; octave = 0, semitone = 4. A fourth 5 gives no pulse.
- Steps 14,14,20,20,20 → one commit only, cur_note = 20, octave = 1, semitone = 7. Step 40 ×3 → cur_note = 0 and no history push.
- Commit notes 1..10 with DEPTH = 8, then pulse frame_start → 8 beats with out_note 10,9,…,3 and out_index 0..7; out_last only on the beat with note 3; first out_valid at F+2.
- frame_start with empty history → one beat, out_note = 0, out_last = 1.
- During SEND with out_ready toggling 1/0, commit 12 then 15 → payload stays stable while stalled; drop pulses once; after FLUSH, the newest history entry is 15.
- Assert reset_n low during beat 3 of 8 → all outputs are 0 at once; after release, count = 0 and the next burst is the single empty beat.
